neuron_weight_seq: RTL
======================

// Module: neuron_weight_seq
// PURPOSE
//  Controller for one neuron's weight BRAM (DEPTH x DW signed, read/write on CLK negedge).
//  LOAD mode: streams DEPTH weights into the BRAM over a valid/ready port.
//  COMPUTE mode: sweeps addresses 0..DEPTH-1 over the weight BRAM and the matching
//  input-feature buffer, and accumulates the signed dot product for the activation stage.
// PARAMETERS
//  DEPTH  28  weights per neuron (BRAM entries)
//  AW     5   address width; 2**AW >= DEPTH
//  DW     16  signed weight / feature width
//  ACC_W  40  signed accumulator width; must satisfy ACC_W >= 2*DW+AW
// PORTS
//  CLK       in   1      clock; all controller logic on posedge
//  RSTN      in   1      synchronous active-low reset
//  START     in   1      begin COMPUTE; sampled only in IDLE
//  LOAD      in   1      begin LOAD; sampled only in IDLE; wins over START
//  LD_VALID  in   1      LD_DATA valid
//  LD_READY  out  1      controller accepts a word (high only in LOAD)
//  LD_DATA   in   DW     weight word to write
//  W_ADDR    out  AW     weight BRAM ADDR
//  W_DI      out  DW     weight BRAM DI
//  W_EN      out  1      weight BRAM EN
//  W_WE      out  1      weight BRAM WE
//  W_DO      in   DW     weight BRAM DO (signed)
//  X_ADDR    out  AW     feature buffer address (== W_ADDR in COMPUTE)
//  X_DATA    in   DW     feature buffer data (signed; same 1-cycle latency as W_DO)
//  BUSY      out  1      high in any state except IDLE
//  DONE      out  1      one-cycle pulse: ACC_OUT valid
//  ACC_OUT   out  ACC_W  signed dot product; held until next START
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE; all outputs 0; counters 0; acc 0.
//  - Reset is honoured in any state. Mid-operation it aborts to IDLE, with no DONE
//    and no further writes. Words already written stay in the BRAM.
//  - States: IDLE, LOAD, FETCH, DRAIN, FIN.
//  - IDLE:
//      LOAD=1  -> LOAD, cnt=0.
//      else START=1 -> FETCH, cnt=0, acc=0.
//      START/LOAD in any other state are ignored.
//  - LOAD:
//      LD_READY=1. Each edge with LD_VALID&LD_READY registers W_ADDR=cnt, W_DI=LD_DATA,
//      W_EN=W_WE=1 for the next cycle; the BRAM writes on that cycle's negedge.
//      Edges without a handshake leave W_EN=W_WE=0.
//      After the DEPTH-th handshake: LD_READY=0 from the next cycle -> IDLE.
//  - FETCH:
//      W_EN=1, W_WE=0 for exactly DEPTH consecutive cycles.
//      W_ADDR=X_ADDR=0,1,..,DEPTH-1 ascending, starting the cycle after the START edge.
//      The BRAM reads at negedge, so data for address k is sampled at the posedge that
//      ends the cycle addressing k. At that edge: acc += sext(W_DO*X_DATA), with a
//      2*DW-bit signed product sign-extended to ACC_W.
//      After the last address: W_EN=0 -> DRAIN.
//  - DRAIN: one cycle (absorbs final product timing margin) -> FIN.
//  - FIN: ACC_OUT<=acc, DONE=1 for one cycle -> IDLE.
//  - Latency: DONE is high in the cycle after posedge DEPTH+2, counting the START edge
//    as edge 0 (edge 30 with default DEPTH). Throughput: one MAC per cycle.
//  - No overflow is possible given the ACC_W rule; no saturation logic.
//  - cnt never wraps past DEPTH-1; unused addresses DEPTH..2**AW-1 are never driven.
//  - W_WE is never 1 while W_EN is 0. W_WE is never 1 outside LOAD.
// TESTING
//  1 Hold RSTN=0 for 2 edges with START/LOAD toggling -> all outputs 0, BUSY=0, no W_EN.
//  2 LOAD, then LD_VALID held high with data k+1 -> 28 write cycles, W_ADDR 0..27,
//    W_DI 1..28; LD_READY low after the 28th handshake; BUSY falls.
//  3 LOAD with LD_VALID high every other cycle -> exactly 28 writes; none on gap cycles;
//    contents match.
//  4 Weights all 1, X[k]=k, START -> W_EN high 28 cycles; single DONE; ACC_OUT=378.
//  5 Weights all -32768, X all 32767 -> ACC_OUT=-30063853568 (no wrap in 40 bits).
//  6 START again during FETCH -> ignored. RSTN=0 at FETCH cycle 10 -> IDLE, no DONE.
//    Next START -> correct fresh result; LOAD+START together in IDLE -> LOAD taken.

Source files
------------

// File: rtl/neuron_weight_seq.sv
// Weight-BRAM controller for one neuron: streams weights in (LOAD), then sweeps
// the weight BRAM and feature buffer together to accumulate a signed dot product.
module neuron_weight_seq #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             LOAD,
  input  logic             LD_VALID,
  output logic             LD_READY,
  input  logic [DW-1:0]    LD_DATA,
  output logic [AW-1:0]    W_ADDR,
  output logic [DW-1:0]    W_DI,
  output logic             W_EN,
  output logic             W_WE,
  input  logic [DW-1:0]    W_DO,
  output logic [AW-1:0]    X_ADDR,
  input  logic [DW-1:0]    X_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [ACC_W-1:0] ACC_OUT
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN, S_FIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ld_ready_q, ld_ready_d;
  logic [AW-1:0]           w_addr_q, w_addr_d;
  logic [AW-1:0]           x_addr_q, x_addr_d;
  logic [DW-1:0]           w_di_q, w_di_d;
  logic                    w_en_q, w_en_d;
  logic                    w_we_q, w_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [ACC_W-1:0]        acc_out_q, acc_out_d;

  // Operands widened before the multiply so the product is a full 2*DW signed value.
  logic signed [2*DW-1:0]  w_s, x_s, prod;
  logic signed [ACC_W-1:0] prod_ext;

  always_comb begin
    w_s      = {{DW{W_DO[DW-1]}}, W_DO};
    x_s      = {{DW{X_DATA[DW-1]}}, X_DATA};
    prod     = w_s * x_s;
    prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ld_ready_d = 1'b0;
    w_addr_d   = w_addr_q;
    x_addr_d   = x_addr_q;
    w_di_d     = w_di_q;
    w_en_d     = 1'b0;
    w_we_d     = 1'b0;
    done_d     = 1'b0;
    acc_out_d  = acc_out_q;

    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          ld_ready_d = 1'b1;
        end else if (START) begin
          state_d  = S_FETCH;
          cnt_d    = '0;
          acc_d    = '0;
          w_en_d   = 1'b1;
          w_addr_d = '0;
          x_addr_d = '0;
        end
      end
      S_LOAD: begin
        ld_ready_d = 1'b1;
        if (LD_VALID && ld_ready_q) begin
          w_en_d   = 1'b1;
          w_we_d   = 1'b1;
          w_addr_d = cnt_q;
          w_di_d   = LD_DATA;
          if (cnt_q == LAST) begin
            ld_ready_d = 1'b0;
            state_d    = S_IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_FETCH: begin
        // Every edge in FETCH closes a read cycle, so its data is always valid here.
        acc_d = acc_q + prod_ext;
        if (cnt_q == LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + AW'(1);
          w_en_d   = 1'b1;
          w_addr_d = cnt_q + AW'(1);
          x_addr_d = cnt_q + AW'(1);
        end
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN: begin
        acc_out_d = acc_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      ld_ready_q <= 1'b0;
      w_addr_q   <= '0;
      x_addr_q   <= '0;
      w_di_q     <= '0;
      w_en_q     <= 1'b0;
      w_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ld_ready_q <= ld_ready_d;
      w_addr_q   <= w_addr_d;
      x_addr_q   <= x_addr_d;
      w_di_q     <= w_di_d;
      w_en_q     <= w_en_d;
      w_we_q     <= w_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_out_q  <= acc_out_d;
    end
  end

  assign LD_READY = ld_ready_q;
  assign W_ADDR   = w_addr_q;
  assign X_ADDR   = x_addr_q;
  assign W_DI     = w_di_q;
  assign W_EN     = w_en_q;
  assign W_WE     = w_we_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ACC_OUT  = acc_out_q;

endmodule
